phv_builder: RTL and testbench
==============================

PHV_BUILDER -- requirements
Module: phv_builder

Interface
REQ-001 Parameter HEAD_WIDTH, default 1024: PHV header width in bits; SHALL be a multiple of 128 and at least 256.
REQ-002 Parameter TAG_WIDTH, default 8: tag field width prepended to PHV and meta.
REQ-003 Parameter META_WIDTH, default 256: metadata width.
REQ-004 Parameter FIFO_DEPTH, default 8: PHV FIFO entries; SHALL be a power of two and at least 2.
REQ-005 Parameter CONF_ETYPE, default 16'h9006: ethertype marking configuration packets.
REQ-006 i_clk  in  1  sole clock; reset is asynchronous and active-low.
REQ-007 i_rst_n  in  1  asynchronous active-low reset.
REQ-008 i_pkt_valid  in  1  input beat valid; no backpressure toward the source.
REQ-009 i_pkt  in  134  beat; [133:132] = 01 head, 10 tail, 11 or 00 middle; [127:0] data.
REQ-010 i_inport  in  8  ingress port, sampled on the head beat.
REQ-011 o_pkt_valid, o_pkt  out  1/134  data beats forwarded.
REQ-012 o_phv_valid, o_phv  out  1/HEAD_WIDTH+TAG_WIDTH  one PHV per packet.
REQ-013 i_phv_ready  in  1  downstream accepts PHV.
REQ-014 o_meta  out  META_WIDTH+TAG_WIDTH  sideband, valid with o_phv_valid.
REQ-015 o_rule_wren, o_rule_addr, o_rule_wdata  out  1/32/32  parser rule write port.
REQ-016 o_drop_cnt  out  16  count of PHVs dropped.

Function
REQ-017 o_pkt SHALL equal i_pkt delayed by one cycle; o_pkt_valid SHALL be registered i_pkt_valid, except that it SHALL be 0 for every beat of a configuration packet.
REQ-018 A head beat with i_pkt[31:16]==CONF_ETYPE SHALL make the packet a configuration packet; every following valid beat through the tail SHALL produce, one cycle later, o_rule_wren=1, o_rule_addr=i_pkt[47:16], o_rule_wdata=i_pkt[79:48].
REQ-019 A configuration packet SHALL produce no PHV.
REQ-020 For other packets, beat k (0 = head) SHALL be written to PHV bits [HEAD_WIDTH-1-128k -: 128] for k < HEAD_WIDTH/128; later beats SHALL be ignored for PHV assembly. The head beat SHALL store all 128 data bits.
REQ-021 Bits of the PHV that no beat writes SHALL be zero.
REQ-022 An i_pkt_valid gap mid-packet SHALL hold the assembly state; the beat index SHALL advance only on valid beats and SHALL saturate at HEAD_WIDTH/128.
REQ-023 On the tail beat the assembled PHV SHALL be pushed into the FIFO on the next cycle.
REQ-024 The pushed PHV tag SHALL have TAG_VALID, TAG_START and TAG_TAIL set and TAG_SHIFT clear.
REQ-025 Meta SHALL carry inport in [7:0] and the beat count (8-bit saturating) in [15:8]; all other meta bits SHALL be zero.
REQ-026 The meta tag SHALL equal the PHV tag.
REQ-027 Output SHALL use a valid/ready handshake: o_phv_valid=1 whenever the FIFO is non-empty. The entry SHALL pop on o_phv_valid & i_phv_ready. o_phv/o_meta SHALL hold stable while not accepted.
REQ-028 Minimum latency from tail beat to o_phv_valid SHALL be 2 cycles.
REQ-029 A push into a full FIFO SHALL be dropped and increment o_drop_cnt, except when a pop occurs in the same cycle, in which case the push SHALL succeed.
REQ-030 A head beat arriving before the tail of the current packet SHALL discard the partial PHV, increment o_drop_cnt, and start the new packet.
REQ-031 o_drop_cnt SHALL saturate at 16'hFFFF.
REQ-032 A tail beat with no packet in progress SHALL be ignored.

Reset
REQ-033 On i_rst_n low, all outputs SHALL be 0 asynchronously, the FIFO SHALL be emptied, the assembly state SHALL be idle, and o_drop_cnt SHALL be 0.
REQ-034 A packet in progress at reset SHALL be lost; the first beat after reset SHALL be accepted only if it is a head beat.

Structure
REQ-035 Shared package phv_pkg SHALL hold the TAG_VALID/SHIFT/START/TAIL bit positions, the beat type codes, the default widths and CONF_ETYPE.
REQ-036 The FIFO SHALL be one sub-module, phv_sync_fifo: first-word-fall-through, parametrised width and depth, with full/empty and simultaneous read/write.

Verification
REQ-037 4-beat packet (HEAD_WIDTH=1024): head, 2 middle, tail; inport=3 -> one PHV with beats 0-3 in the top 512 bits, low 512 bits zero, meta[15:8]=4, o_phv_valid 2 cycles after tail.
REQ-038 Configuration packet: ethertype 9006, 3 beats -> 2 rule writes with addr/wdata from beat bits [47:16]/[79:48], o_pkt_valid 0 throughout, no PHV.
REQ-039 i_phv_ready=0, send FIFO_DEPTH+2 packets -> FIFO_DEPTH PHVs retained in order, o_drop_cnt=2, o_phv stable; release ready -> all pop in order.
REQ-040 Head, middle, then a new head before any tail -> o_drop_cnt=1, only the second packet yields a PHV.
REQ-041 12-beat packet with valid gaps -> PHV holds beats 0-7, meta beat count 12.
REQ-042 Assert reset mid-packet with 3 PHVs queued -> outputs 0, FIFO empty, no PHV from the aborted packet.

Source files
------------

// File: rtl/phv_pkg.sv
// Shared definitions for the PHV builder: tag bit positions, beat codes and defaults.
package phv_pkg;

  // Tag bit positions inside the tag prepended to PHV and meta
  localparam int TAG_VALID = 0;
  localparam int TAG_SHIFT = 1;
  localparam int TAG_START = 2;
  localparam int TAG_TAIL  = 3;

  // Beat type codes carried in i_pkt[133:132]; both 00 and 11 mean middle
  typedef enum logic [1:0] {
    BEAT_MID_A = 2'b00,
    BEAT_HEAD  = 2'b01,
    BEAT_TAIL  = 2'b10,
    BEAT_MID_B = 2'b11
  } beat_t;

  // Default widths and the configuration ethertype
  localparam int          DEF_HEAD_WIDTH = 1024;
  localparam int          DEF_TAG_WIDTH  = 8;
  localparam int          DEF_META_WIDTH = 256;
  localparam int          DEF_FIFO_DEPTH = 8;
  localparam logic [15:0] DEF_CONF_ETYPE = 16'h9006;

endpackage

// File: rtl/phv_sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty and same-cycle read/write.
// Read data is forced to zero while empty so nothing stale leaks after reset.
module phv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_rd, do_wr;

  assign o_full    = (count_q == (AW+1)'(DEPTH));
  assign o_empty   = (count_q == '0);
  assign do_rd     = i_rd_en && !o_empty;
  // A write into a full FIFO is allowed when an entry leaves in the same cycle
  assign do_wr     = i_wr_en && (!o_full || do_rd);
  assign o_rd_data = o_empty ? '0 : mem_q[rd_ptr_q];

  // Storage array, written without reset
  always_ff @(posedge i_clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= i_wr_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_wr && !do_rd)      count_q <= count_q + (AW+1)'(1);
      else if (do_rd && !do_wr) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/phv_builder.sv
// Assembles the first HEAD_WIDTH bits of each packet into a tagged PHV, turns
// configuration packets into parser rule writes, and queues PHVs for downstream.
module phv_builder
  import phv_pkg::*;
#(
  parameter int          HEAD_WIDTH = DEF_HEAD_WIDTH,
  parameter int          TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int          META_WIDTH = DEF_META_WIDTH,
  parameter int          FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [15:0] CONF_ETYPE = DEF_CONF_ETYPE
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_pkt_valid,
  input  logic [133:0]                     i_pkt,
  input  logic [7:0]                       i_inport,
  output logic                             o_pkt_valid,
  output logic [133:0]                     o_pkt,
  output logic                             o_phv_valid,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0]  o_phv,
  input  logic                             i_phv_ready,
  output logic [META_WIDTH+TAG_WIDTH-1:0]  o_meta,
  output logic                             o_rule_wren,
  output logic [31:0]                      o_rule_addr,
  output logic [31:0]                      o_rule_wdata,
  output logic [15:0]                      o_drop_cnt
);

  localparam int NB   = HEAD_WIDTH / 128;
  localparam int IDXW = $clog2(NB + 1);
  localparam int PW   = HEAD_WIDTH + TAG_WIDTH;
  localparam int MW   = META_WIDTH + TAG_WIDTH;
  localparam int FW   = PW + MW;
  localparam logic [TAG_WIDTH-1:0] PUSH_TAG =
    TAG_WIDTH'((1 << TAG_VALID) | (1 << TAG_START) | (1 << TAG_TAIL));

  logic [133:0]          pkt_q;
  logic                  pkt_valid_q, pkt_valid_d;
  logic                  rule_wren_q, rule_wren_d;
  logic [31:0]           rule_addr_q, rule_addr_d, rule_wdata_q, rule_wdata_d;
  logic                  in_pkt_q, in_pkt_d, conf_q, conf_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [7:0]            cnt_q, cnt_d, inport_q, inport_d;
  logic [HEAD_WIDTH-1:0] phv_q, phv_d;
  logic                  push_q, push_d;
  logic [FW-1:0]         push_data_q, push_data_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic [META_WIDTH-1:0] meta_d;
  logic                  is_head, is_tail, is_conf_head, drop_head, drop_full;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [FW-1:0]         fifo_rd_data;
  logic [1:0]            drop_inc;
  logic [16:0]           drop_sum;

  assign is_head      = i_pkt_valid && (i_pkt[133:132] == BEAT_HEAD);
  assign is_tail      = i_pkt_valid && (i_pkt[133:132] == BEAT_TAIL);
  assign is_conf_head = is_head && (i_pkt[31:16] == CONF_ETYPE);
  assign fifo_pop     = !fifo_empty && i_phv_ready;
  assign drop_full    = push_q && fifo_full && !fifo_pop;

  // Beat-by-beat assembly, configuration decoding and drop accounting
  always_comb begin
    pkt_valid_d  = i_pkt_valid && !is_conf_head && !(in_pkt_q && conf_q && !is_head);
    rule_wren_d  = 1'b0;
    rule_addr_d  = rule_addr_q;
    rule_wdata_d = rule_wdata_q;
    in_pkt_d     = in_pkt_q;
    conf_d       = conf_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    inport_d     = inport_q;
    phv_d        = phv_q;
    push_d       = 1'b0;
    push_data_d  = push_data_q;
    drop_head    = 1'b0;
    meta_d       = '0;
    if (is_head) begin
      // A head mid-packet abandons the partial PHV; configuration packets carry none
      drop_head = in_pkt_q && !conf_q;
      in_pkt_d  = 1'b1;
      conf_d    = is_conf_head;
      phv_d     = '0;
      phv_d[HEAD_WIDTH-1 -: 128] = i_pkt[127:0];
      idx_d     = IDXW'(1);
      cnt_d     = 8'd1;
      inport_d  = i_inport;
    end else if (i_pkt_valid && in_pkt_q) begin
      if (conf_q) begin
        rule_wren_d  = 1'b1;
        rule_addr_d  = i_pkt[47:16];
        rule_wdata_d = i_pkt[79:48];
      end else begin
        for (int k = 0; k < NB; k++) begin
          if (idx_q == IDXW'(k)) phv_d[HEAD_WIDTH-1-128*k -: 128] = i_pkt[127:0];
        end
        if (idx_q != IDXW'(NB)) idx_d = idx_q + IDXW'(1);
        if (cnt_q != 8'hFF)     cnt_d = cnt_q + 8'd1;
      end
      if (is_tail) begin
        in_pkt_d = 1'b0;
        conf_d   = 1'b0;
        if (!conf_q) begin
          meta_d[7:0]  = inport_q;
          meta_d[15:8] = cnt_d;
          push_d       = 1'b1;
          push_data_d  = {PUSH_TAG, phv_d, PUSH_TAG, meta_d};
        end
      end
    end
    drop_inc   = {1'b0, drop_head} + {1'b0, drop_full};
    drop_sum   = {1'b0, drop_cnt_q} + {15'd0, drop_inc};
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_q        <= '0;
      pkt_valid_q  <= 1'b0;
      rule_wren_q  <= 1'b0;
      rule_addr_q  <= '0;
      rule_wdata_q <= '0;
      in_pkt_q     <= 1'b0;
      conf_q       <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      inport_q     <= '0;
      phv_q        <= '0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      pkt_q        <= i_pkt;
      pkt_valid_q  <= pkt_valid_d;
      rule_wren_q  <= rule_wren_d;
      rule_addr_q  <= rule_addr_d;
      rule_wdata_q <= rule_wdata_d;
      in_pkt_q     <= in_pkt_d;
      conf_q       <= conf_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      inport_q     <= inport_d;
      phv_q        <= phv_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  phv_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (push_q),
    .i_wr_data (push_data_q),
    .i_rd_en   (fifo_pop),
    .o_rd_data (fifo_rd_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  assign o_pkt        = pkt_q;
  assign o_pkt_valid  = pkt_valid_q;
  assign o_rule_wren  = rule_wren_q;
  assign o_rule_addr  = rule_addr_q;
  assign o_rule_wdata = rule_wdata_q;
  assign o_drop_cnt   = drop_cnt_q;
  assign o_phv_valid  = !fifo_empty;
  assign o_phv        = fifo_rd_data[FW-1 -: PW];
  assign o_meta       = fifo_rd_data[MW-1:0];

endmodule

// File: tb/tb_phv_builder.sv
// Directed bench for phv_builder: vector table of single packets plus hand-written
// sequences for latency, configuration, backpressure, early head and reset.
module tb_phv_builder;
  import phv_pkg::*;

  localparam int HW  = 1024;
  localparam int TW  = 8;
  localparam int MW  = 256;
  localparam int PW  = HW + TW;
  localparam int MWT = MW + TW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           pkt_valid = 1'b0;
  logic [133:0]   pkt = '0;
  logic [7:0]     inport = '0;
  logic           phv_ready = 1'b0;
  logic           o_pkt_valid, o_phv_valid, o_rule_wren;
  logic [133:0]   o_pkt;
  logic [PW-1:0]  o_phv;
  logic [MWT-1:0] o_meta;
  logic [31:0]    o_rule_addr, o_rule_wdata;
  logic [15:0]    o_drop_cnt;

  always #5 clk = ~clk;

  phv_builder dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pkt_valid  (pkt_valid),
    .i_pkt        (pkt),
    .i_inport     (inport),
    .o_pkt_valid  (o_pkt_valid),
    .o_pkt        (o_pkt),
    .o_phv_valid  (o_phv_valid),
    .o_phv        (o_phv),
    .i_phv_ready  (phv_ready),
    .o_meta       (o_meta),
    .o_rule_wren  (o_rule_wren),
    .o_rule_addr  (o_rule_addr),
    .o_rule_wdata (o_rule_wdata),
    .o_drop_cnt   (o_drop_cnt)
  );

  int tests = 0;
  int fails = 0;

  typedef struct { logic [PW-1:0] phv; logic [MWT-1:0] meta; } cap_t;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; } rule_t;
  cap_t  capq[$];
  rule_t ruleq[$];
  int    pktv_cnt = 0;

  // Record accepted PHVs, rule writes and forwarded beats on the falling edge
  always @(negedge clk) begin
    if (rst_n && o_phv_valid && phv_ready) capq.push_back('{o_phv, o_meta});
    if (o_rule_wren) ruleq.push_back('{o_rule_addr, o_rule_wdata});
    if (o_pkt_valid) pktv_cnt++;
  end

  typedef struct {
    int          nbeats;
    logic [7:0]  port;
    logic [15:0] seed;
    bit          gaps;
    int          exp_slots;
    logic [7:0]  exp_cnt;
  } vec_t;
  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] bdata(logic [15:0] seed, int k);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[32*i +: 32] = {seed, 16'(k)};
    return d;
  endfunction

  function automatic logic [TW-1:0] exp_tag();
    logic [TW-1:0] t;
    t = '0;
    t[TAG_VALID] = 1'b1;
    t[TAG_START] = 1'b1;
    t[TAG_TAIL]  = 1'b1;
    return t;
  endfunction

  function automatic logic [PW-1:0] exp_phv(logic [15:0] seed, int slots);
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < slots; k++) p[HW-1-128*k -: 128] = bdata(seed, k);
    p[PW-1 -: TW] = exp_tag();
    return p;
  endfunction

  function automatic logic [MWT-1:0] exp_meta(logic [7:0] cnt, logic [7:0] port);
    logic [MWT-1:0] m;
    m = '0;
    m[7:0]  = port;
    m[15:8] = cnt;
    m[MWT-1 -: TW] = exp_tag();
    return m;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_phv(string name, logic [PW-1:0] phv, logic [MWT-1:0] meta,
                         logic [PW-1:0] ephv, logic [MWT-1:0] emeta);
    int slot;
    tests++;
    if (phv !== ephv || meta !== emeta) begin
      fails++;
      slot = 0;
      for (int k = 7; k >= 0; k--)
        if (phv[HW-1-128*k -: 128] !== ephv[HW-1-128*k -: 128]) slot = k;
      $display("FAIL %s: tag %h/%h slot%0d %h expected %h meta[15:0] %h expected %h metatag %h/%h",
               name, phv[PW-1 -: TW], ephv[PW-1 -: TW], slot, phv[HW-1-128*slot -: 128],
               ephv[HW-1-128*slot -: 128], meta[15:0], emeta[15:0],
               meta[MWT-1 -: TW], emeta[MWT-1 -: TW]);
    end
  endtask

  task automatic drive(logic [1:0] t, logic [127:0] d, logic [7:0] port);
    pkt_valid = 1'b1;
    pkt       = {t, 4'h0, d};
    inport    = port;
    step();
    pkt_valid = 1'b0;
  endtask

  task automatic send_pkt(int n, logic [15:0] seed, logic [7:0] port, bit gaps);
    logic [1:0] t;
    for (int k = 0; k < n; k++) begin
      t = (k == 0) ? 2'b01 : ((k == n-1) ? 2'b10 : 2'b11);
      drive(t, bdata(seed, k), port);
      if (gaps && (k % 3 == 1)) step();
    end
  endtask

  task automatic wait_caps(string name, int n, int budget);
    int c;
    c = 0;
    while (capq.size() < n && c < budget) begin
      step();
      c++;
    end
    chk(name, 128'(capq.size()), 128'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    capq.delete();
    ruleq.delete();
  endtask

  logic [127:0] d;

  initial begin
    vecs[0] = '{4,   8'd3,   16'h1111, 1'b0, 4, 8'd4};
    vecs[1] = '{2,   8'd9,   16'h2222, 1'b0, 2, 8'd2};
    vecs[2] = '{8,   8'hA5,  16'h3333, 1'b0, 8, 8'd8};
    vecs[3] = '{9,   8'h10,  16'h4444, 1'b0, 8, 8'd9};
    vecs[4] = '{12,  8'h07,  16'h5555, 1'b1, 8, 8'd12};
    vecs[5] = '{3,   8'hFF,  16'h6666, 1'b1, 3, 8'd3};
    vecs[6] = '{260, 8'h01,  16'h7777, 1'b0, 8, 8'hFF};

    // Reset state
    step();
    chk("rst_phv_valid", 128'(o_phv_valid), 128'(0));
    chk("rst_pkt_valid", 128'(o_pkt_valid), 128'(0));
    chk("rst_rule_wren", 128'(o_rule_wren), 128'(0));
    chk("rst_drop_cnt",  128'(o_drop_cnt),  128'(0));
    chk("rst_meta",      128'(o_meta),      128'(0));
    rst_n = 1'b1;
    step();

    // 4-beat packet: latency, forwarding and content while held
    phv_ready = 1'b0;
    drive(2'b01, bdata(16'h0ABC, 0), 8'd3);
    drive(2'b00, bdata(16'h0ABC, 1), 8'd3);
    drive(2'b11, bdata(16'h0ABC, 2), 8'd3);
    drive(2'b10, bdata(16'h0ABC, 3), 8'd3);
    chk("fwd_valid", 128'(o_pkt_valid), 128'(1));
    chk("fwd_data",  o_pkt[127:0], bdata(16'h0ABC, 3));
    chk("lat1_phv_valid", 128'(o_phv_valid), 128'(0));
    step();
    chk("lat2_phv_valid", 128'(o_phv_valid), 128'(1));
    chk_phv("lat_phv", o_phv, o_meta, exp_phv(16'h0ABC, 4), exp_meta(8'd4, 8'd3));
    phv_ready = 1'b1;
    step();
    chk("pop_empty", 128'(o_phv_valid), 128'(0));
    capq.delete();

    // Table of single packets
    for (int v = 0; v < 7; v++) begin
      capq.delete();
      send_pkt(vecs[v].nbeats, vecs[v].seed, vecs[v].port, vecs[v].gaps);
      wait_caps($sformatf("vec%0d_count", v), 1, 20);
      if (capq.size() >= 1)
        chk_phv($sformatf("vec%0d_phv", v), capq[0].phv, capq[0].meta,
                exp_phv(vecs[v].seed, vecs[v].exp_slots),
                exp_meta(vecs[v].exp_cnt, vecs[v].port));
    end

    // Configuration packet
    step();
    step();
    capq.delete();
    ruleq.delete();
    pktv_cnt = 0;
    drive(2'b01, bdata(16'h9006, 0), 8'd2);
    d = '0; d[47:16] = 32'hA0A0_0001; d[79:48] = 32'hDEAD_BEEF;
    drive(2'b11, d, 8'd2);
    d = '0; d[47:16] = 32'h0000_0042; d[79:48] = 32'h1234_5678;
    drive(2'b10, d, 8'd2);
    repeat (5) step();
    chk("conf_rule_count", 128'(ruleq.size()), 128'(2));
    if (ruleq.size() == 2) begin
      chk("conf_addr0",  128'(ruleq[0].addr),  128'(32'hA0A0_0001));
      chk("conf_wdata0", 128'(ruleq[0].wdata), 128'(32'hDEAD_BEEF));
      chk("conf_addr1",  128'(ruleq[1].addr),  128'(32'h0000_0042));
      chk("conf_wdata1", 128'(ruleq[1].wdata), 128'(32'h1234_5678));
    end
    chk("conf_pkt_valid", 128'(pktv_cnt), 128'(0));
    chk("conf_no_phv", 128'(capq.size()), 128'(0));

    // Backpressure: 10 packets into 8 entries
    do_reset();
    phv_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_pkt(2, 16'hA000 + 16'(i), 8'(i), 1'b0);
    repeat (4) step();
    chk("bp_drop_cnt", 128'(o_drop_cnt), 128'(2));
    chk_phv("bp_head", o_phv, o_meta, exp_phv(16'hA000, 2), exp_meta(8'd2, 8'd0));
    repeat (6) step();
    chk_phv("bp_stable", o_phv, o_meta, exp_phv(16'hA000, 2), exp_meta(8'd2, 8'd0));
    phv_ready = 1'b1;
    wait_caps("bp_count", 8, 40);
    repeat (4) step();
    chk("bp_no_extra", 128'(capq.size()), 128'(8));
    for (int i = 0; i < 8 && i < capq.size(); i++)
      chk_phv($sformatf("bp_order%0d", i), capq[i].phv, capq[i].meta,
              exp_phv(16'hA000 + 16'(i), 2), exp_meta(8'd2, 8'(i)));

    // Push into a full FIFO in the same cycle as a pop
    do_reset();
    phv_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_pkt(2, 16'hE000 + 16'(i), 8'(i), 1'b0);
    repeat (3) step();
    drive(2'b01, bdata(16'hE008, 0), 8'd8);
    drive(2'b10, bdata(16'hE008, 1), 8'd8);
    phv_ready = 1'b1;
    wait_caps("full_pop_count", 9, 40);
    chk("full_pop_drop", 128'(o_drop_cnt), 128'(0));
    if (capq.size() >= 9)
      chk_phv("full_pop_last", capq[8].phv, capq[8].meta,
              exp_phv(16'hE008, 2), exp_meta(8'd2, 8'd8));

    // New head before tail
    do_reset();
    phv_ready = 1'b1;
    drive(2'b01, bdata(16'hB001, 0), 8'd4);
    drive(2'b11, bdata(16'hB001, 1), 8'd4);
    drive(2'b01, bdata(16'hB002, 0), 8'd5);
    drive(2'b11, bdata(16'hB002, 1), 8'd5);
    drive(2'b10, bdata(16'hB002, 2), 8'd5);
    wait_caps("early_head_count", 1, 20);
    repeat (3) step();
    chk("early_head_only_one", 128'(capq.size()), 128'(1));
    chk("early_head_drop", 128'(o_drop_cnt), 128'(1));
    if (capq.size() >= 1)
      chk_phv("early_head_phv", capq[0].phv, capq[0].meta,
              exp_phv(16'hB002, 3), exp_meta(8'd3, 8'd5));

    // Reset mid-packet with 3 PHVs queued
    do_reset();
    phv_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_pkt(2, 16'hC000 + 16'(i), 8'(i), 1'b0);
    repeat (3) step();
    chk("rq_valid_before", 128'(o_phv_valid), 128'(1));
    drive(2'b01, bdata(16'hC009, 0), 8'd9);
    drive(2'b11, bdata(16'hC009, 1), 8'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("rq_phv_valid", 128'(o_phv_valid), 128'(0));
    chk("rq_phv_hi",    o_phv[PW-1 -: 128], 128'(0));
    chk("rq_meta",      128'(o_meta), 128'(0));
    chk("rq_pkt_valid", 128'(o_pkt_valid), 128'(0));
    chk("rq_pkt",       128'(o_pkt), 128'(0));
    step();
    rst_n = 1'b1;
    step();
    capq.delete();
    phv_ready = 1'b1;
    drive(2'b11, bdata(16'hC009, 2), 8'd9);
    drive(2'b10, bdata(16'hC009, 3), 8'd9);
    repeat (5) step();
    chk("rq_no_phv", 128'(capq.size()), 128'(0));
    chk("rq_drop", 128'(o_drop_cnt), 128'(0));
    send_pkt(4, 16'hD000, 8'd6, 1'b0);
    wait_caps("rq_after_count", 1, 20);
    if (capq.size() >= 1)
      chk_phv("rq_after_phv", capq[0].phv, capq[0].meta,
              exp_phv(16'hD000, 4), exp_meta(8'd4, 8'd6));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
